// File: rtl/capture_crop_scale_pkg.sv
// Shared types and helpers for the camera capture / crop / scale front end.
package cap_pkg;
  typedef enum logic [1:0] {IDLE, ARMED, CAPT, DONE} cap_state_e;

  localparam int MAX_SCALE = 7;

  // Only 1, 2 and 4 are averaged; other factors fall back to decimation.
  function automatic logic [1:0] log2_scale(input logic [2:0] s);
    case (s)
      3'd2:    return 2'd1;
      3'd4:    return 2'd2;
      default: return 2'd0;
    endcase
  endfunction
endpackage

// File: rtl/cap_scale_acc.sv
// Per-channel group accumulator: emits either the first pixel of a horizontal
// group (decimate) or the group sum shifted down by log2(scale) (average).
module cap_scale_acc #(
  parameter int PW = 8
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          i_en,
  input  logic          i_first,
  input  logic          i_done,
  input  logic          i_avg,
  input  logic [1:0]    i_sh,
  input  logic [PW-1:0] i_pix,
  output logic [PW-1:0] o_pix
);
  logic [PW+1:0] r_sum, w_sum, w_avg;
  logic [PW-1:0] r_first, r_out;

  assign w_sum = i_first ? {2'b00, i_pix} : r_sum + {2'b00, i_pix};
  assign w_avg = w_sum >> i_sh;
  assign o_pix = r_out;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_sum   <= '0;
      r_first <= '0;
      r_out   <= '0;
    end else begin
      if (i_en) begin
        r_sum <= w_sum;
        if (i_first) r_first <= i_pix;
      end
      if (i_done) r_out <= i_avg ? w_avg[PW-1:0] : (i_first ? i_pix : r_first);
    end
  end
endmodule

// File: rtl/capture_crop_scale.sv
// Camera capture front end: crops a window from the raster stream, scales it
// down by an integer factor and writes packed pixels linearly into the frame buffer.
module capture_crop_scale
  import cap_pkg::*;
#(
  parameter int PW = 8,
  parameter int CH = 1,
  parameter int XW = 11,
  parameter int YW = 10,
  parameter int AW = 16
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [2:0]       cfg_scale,
  input  logic             cfg_avg,
  input  logic             cfg_cont,
  input  logic [XW-1:0]    cfg_x,
  input  logic [YW-1:0]    cfg_y,
  input  logic [XW-1:0]    cfg_w,
  input  logic [YW-1:0]    cfg_h,
  input  logic [AW-1:0]    cfg_base,
  input  logic             arm,
  input  logic             cam_vsync_i,
  input  logic             cam_href_i,
  input  logic [CH*PW-1:0] cam_data_i,
  output logic             cenb_frame_buf,
  output logic [AW-1:0]    ab_frame_buf,
  output logic [CH*PW-1:0] db_frame_buf,
  output logic             capture_ready,
  output logic             short_frame,
  output logic             busy
);
  localparam int SW = $clog2(MAX_SCALE + 1);
  localparam int WW = XW + YW;

  cap_state_e       r_state;
  logic             r_vs1, r_vs2, r_vs3, r_hr1, r_hr2, r_hr3, r_pend;
  logic [CH*PW-1:0] r_d1, r_d2, w_acc;
  logic [SW-1:0]    r_scale, r_gcnt, r_lcnt;
  logic             r_avg, r_cont;
  logic [XW-1:0]    r_x, r_w, r_cnt_h;
  logic [YW-1:0]    r_y, r_h, r_cnt_v;
  logic [WW-1:0]    r_wh, r_wcnt;
  logic [1:0]       r_vld_pipe;
  logic [XW:0]      w_xend;
  logic [YW:0]      w_yend;
  logic             w_vs_fall, w_vs_rise, w_hr_fall, w_first, w_gdone;
  logic             w_in_win, w_wr, w_full, w_start, w_avg_en;
  logic [1:0]       w_sh;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      {r_vs1, r_vs2, r_vs3, r_hr1, r_hr2, r_hr3} <= '0;
      r_d1 <= '0;
      r_d2 <= '0;
    end else begin
      {r_vs3, r_vs2, r_vs1} <= {r_vs2, r_vs1, cam_vsync_i};
      {r_hr3, r_hr2, r_hr1} <= {r_hr2, r_hr1, cam_href_i};
      r_d1 <= cam_data_i;
      r_d2 <= r_d1;
    end
  end

  assign w_vs_fall = r_vs3 & ~r_vs2;
  assign w_vs_rise = ~r_vs3 & r_vs2;
  assign w_hr_fall = r_hr3 & ~r_hr2;
  assign w_start   = (r_state == ARMED) && w_vs_fall;
  assign w_first   = r_hr2 && (r_gcnt == '0);
  assign w_gdone   = r_hr2 && (r_gcnt == r_scale - SW'(1));
  assign w_sh      = log2_scale(r_scale);
  assign w_avg_en  = r_avg && (r_scale == SW'(1) || r_scale == SW'(2) || r_scale == SW'(4));

  // Window bounds carry one extra bit so x+w / y+h never wrap.
  assign w_xend   = {1'b0, r_x} + {1'b0, r_w};
  assign w_yend   = {1'b0, r_y} + {1'b0, r_h};
  assign w_in_win = (r_cnt_h >= r_x) && ({1'b0, r_cnt_h} < w_xend) &&
                    (r_cnt_v >= r_y) && ({1'b0, r_cnt_v} < w_yend) && (r_lcnt == '0);
  assign w_wr     = w_gdone && w_in_win && (r_state == CAPT) && (r_wcnt < r_wh);
  assign w_full   = (r_wh != '0) && (r_wcnt == r_wh);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_gcnt  <= '0;
      r_cnt_h <= '0;
      r_lcnt  <= '0;
      r_cnt_v <= '0;
    end else begin
      if (!r_hr2) begin
        r_gcnt  <= '0;
        r_cnt_h <= '0;
      end else if (w_gdone) begin
        r_gcnt  <= '0;
        r_cnt_h <= r_cnt_h + XW'(1);
      end else begin
        r_gcnt  <= r_gcnt + SW'(1);
      end
      if (w_vs_fall) begin
        r_lcnt  <= '0;
        r_cnt_v <= '0;
      end else if (w_hr_fall) begin
        if (r_lcnt == r_scale - SW'(1)) begin
          r_lcnt  <= '0;
          r_cnt_v <= r_cnt_v + YW'(1);
        end else begin
          r_lcnt  <= r_lcnt + SW'(1);
        end
      end
    end
  end

  for (genvar c = 0; c < CH; c++) begin : g_ch
    cap_scale_acc #(.PW(PW)) u_acc (
      .clk     (clk),
      .rstn    (rstn),
      .i_en    (r_hr2),
      .i_first (w_first),
      .i_done  (w_gdone),
      .i_avg   (w_avg_en),
      .i_sh    (w_sh),
      .i_pix   (r_d2[c*PW +: PW]),
      .o_pix   (w_acc[c*PW +: PW])
    );
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state       <= IDLE;
      r_pend        <= 1'b0;
      busy          <= 1'b0;
      capture_ready <= 1'b0;
      short_frame   <= 1'b0;
      r_wcnt        <= '0;
      r_wh          <= '0;
      r_scale       <= SW'(1);
      r_avg         <= 1'b0;
      r_cont        <= 1'b0;
      r_x           <= '0;
      r_y           <= '0;
      r_w           <= '0;
      r_h           <= '0;
    end else begin
      capture_ready <= 1'b0;
      if (arm) short_frame <= 1'b0;
      if (w_wr) r_wcnt <= r_wcnt + WW'(1);
      case (r_state)
        IDLE: if (arm) begin
          r_state <= ARMED;
          busy    <= 1'b1;
        end
        ARMED: if (w_vs_fall) begin
          r_state <= CAPT;
          r_wcnt  <= '0;
          r_scale <= (cfg_scale == '0) ? SW'(1) : cfg_scale;
          r_avg   <= cfg_avg;
          r_cont  <= cfg_cont;
          r_x     <= cfg_x;
          r_y     <= cfg_y;
          r_w     <= cfg_w;
          r_h     <= cfg_h;
          r_wh    <= WW'(cfg_w) * WW'(cfg_h);
        end
        CAPT: begin
          if (arm) r_pend <= 1'b1;
          if (w_full || w_vs_rise) begin
            r_state     <= DONE;
            short_frame <= (r_wcnt != r_wh);
          end
        end
        DONE: begin
          capture_ready <= 1'b1;
          r_pend        <= 1'b0;
          if (r_cont || r_pend || arm) begin
            r_state <= ARMED;
          end else begin
            r_state <= IDLE;
            busy    <= 1'b0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Stage 0 holds the registered group result, stage 1 is the SRAM write cycle.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_vld_pipe   <= '0;
      db_frame_buf <= '0;
      ab_frame_buf <= '0;
    end else begin
      r_vld_pipe <= {r_vld_pipe[0], w_wr};
      if (r_vld_pipe[0]) db_frame_buf <= w_acc;
      if (w_start) ab_frame_buf <= cfg_base;
      else if (r_vld_pipe[1]) ab_frame_buf <= ab_frame_buf + AW'(1);
    end
  end

  assign cenb_frame_buf = ~r_vld_pipe[1];
endmodule

// File: tb/tb_capture_crop_scale.sv
// Directed bench for capture_crop_scale: drives raster frames and checks the
// frame-buffer write stream, handshake pulses and reset behaviour.
module tb_capture_crop_scale;
  logic        clk = 1'b0;
  logic        rstn;
  logic [2:0]  cfg_scale;
  logic        cfg_avg, cfg_cont;
  logic [10:0] cfg_x, cfg_w;
  logic [9:0]  cfg_y, cfg_h;
  logic [15:0] cfg_base;
  logic        arm, vsync, href;
  logic [7:0]  data;
  logic        cenb, ready, short_f, busy;
  logic [15:0] ab;
  logic [7:0]  db;

  capture_crop_scale dut (
    .clk(clk), .rstn(rstn), .cfg_scale(cfg_scale), .cfg_avg(cfg_avg), .cfg_cont(cfg_cont),
    .cfg_x(cfg_x), .cfg_y(cfg_y), .cfg_w(cfg_w), .cfg_h(cfg_h), .cfg_base(cfg_base),
    .arm(arm), .cam_vsync_i(vsync), .cam_href_i(href), .cam_data_i(data),
    .cenb_frame_buf(cenb), .ab_frame_buf(ab), .db_frame_buf(db),
    .capture_ready(ready), .short_frame(short_f), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_err = 0;
  int cyc = 0, rdy_n = 0;
  int wa[$], wd[$], wcy[$];
  int bw, br, t_drv, lat_r, lat_c, npre;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rstn && !cenb) begin
      wa.push_back(int'(ab));
      wd.push_back(int'(db));
      wcy.push_back(cyc);
    end
    if (ready) rdy_n++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int nw();
    return wa.size() - bw;
  endfunction

  function automatic logic [7:0] pix(input int pat, input int r, input int c);
    if (pat == 1) begin
      if (r % 2 == 1) return 8'd100;
      case (c % 4)
        0:       return 8'd10;
        1:       return 8'd20;
        2:       return 8'd30;
        default: return 8'd41;
      endcase
    end
    return 8'(r * 16 + c);
  endfunction

  task automatic cfgset(input int s, input int a, input int ct, input int x, input int y,
                        input int w, input int h, input int base);
    cfg_scale = 3'(s);  cfg_avg = 1'(a);  cfg_cont = 1'(ct);
    cfg_x = 11'(x);  cfg_y = 10'(y);  cfg_w = 11'(w);  cfg_h = 10'(h);
    cfg_base = 16'(base);
  endtask

  task automatic do_arm();
    arm = 1'b1;
    @(negedge clk);
    arm = 1'b0;
    @(negedge clk);
  endtask

  task automatic mark();
    bw = wa.size();
    br = rdy_n;
  endtask

  task automatic frame(input int W, input int H, input int pat, input int arm_row);
    vsync = 1'b1;
    repeat (4) @(negedge clk);
    vsync = 1'b0;
    repeat (3) @(negedge clk);
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        href = 1'b1;
        data = pix(pat, r, c);
        arm  = (r == arm_row && c == 0);
        if (r == lat_r && c == lat_c) t_drv = cyc;
        @(negedge clk);
      end
      href = 1'b0;
      arm  = 1'b0;
      data = '0;
      repeat (3) @(negedge clk);
    end
    vsync = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  initial begin
    rstn = 1'b0; arm = 1'b0; vsync = 1'b1; href = 1'b0; data = '0;
    lat_r = -1; lat_c = -1; t_drv = 0;
    cfgset(1, 0, 0, 0, 0, 0, 0, 0);
    mark();
    repeat (3) @(negedge clk);
    chk("rst_cenb", 32'(cenb), 1);
    chk("rst_ab", 32'(ab), 0);
    chk("rst_db", 32'(db), 0);
    chk("rst_ready", 32'(ready), 0);
    chk("rst_short", 32'(short_f), 0);
    chk("rst_busy", 32'(busy), 0);
    rstn = 1'b1;
    @(negedge clk);

    // scale 1 decimate crop of a ramp frame
    cfgset(1, 0, 0, 2, 1, 4, 3, 'h40);
    lat_r = 1; lat_c = 2;
    do_arm();
    chk("t1_busy_armed", 32'(busy), 1);
    mark();
    frame(16, 8, 0, -1);
    chk("t1_nwr", nw(), 12);
    for (int i = 0; i < 12 && i < nw(); i++) begin
      chk("t1_addr", wa[bw+i], 'h40 + i);
      chk("t1_data", wd[bw+i], (1 + i / 4) * 16 + 2 + i % 4);
    end
    if (nw() > 0) chk("t1_latency", wcy[bw] - t_drv, 4);
    chk("t1_ready", rdy_n - br, 1);
    chk("t1_short", 32'(short_f), 0);
    chk("t1_idle", 32'(busy), 0);
    lat_r = -1;

    // scale 2 average, odd lines skipped, address wraps
    cfgset(2, 1, 0, 0, 0, 2, 2, 'hFFFE);
    do_arm();
    mark();
    frame(4, 4, 1, -1);
    chk("t2_nwr", nw(), 4);
    for (int i = 0; i < 4 && i < nw(); i++) begin
      chk("t2_addr", wa[bw+i], ('hFFFE + i) & 'hFFFF);
      chk("t2_data", wd[bw+i], (i % 2 == 0) ? 15 : 35);
    end
    chk("t2_ready", rdy_n - br, 1);

    // scale 3 with average requested falls back to decimate
    cfgset(3, 1, 0, 0, 0, 4, 1, 'h200);
    do_arm();
    mark();
    frame(12, 3, 0, -1);
    chk("t3_nwr", nw(), 4);
    for (int i = 0; i < 4 && i < nw(); i++) begin
      chk("t3_addr", wa[bw+i], 'h200 + i);
      chk("t3_data", wd[bw+i], 3 * i);
    end

    // window taller than the frame: short frame
    cfgset(1, 0, 0, 0, 0, 2, 5, 'h300);
    do_arm();
    mark();
    frame(8, 2, 0, -1);
    chk("t4_nwr", nw(), 4);
    if (nw() == 4) chk("t4_last_data", wd[bw+3], 17);
    chk("t4_ready", rdy_n - br, 1);
    chk("t4_short", 32'(short_f), 1);

    // window entirely outside the frame
    cfgset(1, 0, 0, 20, 0, 2, 1, 0);
    do_arm();
    chk("t4b_short_clr", 32'(short_f), 0);
    mark();
    frame(8, 2, 0, -1);
    chk("t4b_nwr", nw(), 0);
    chk("t4b_ready", rdy_n - br, 1);
    chk("t4b_short", 32'(short_f), 1);

    // zero-width window
    cfgset(1, 0, 0, 0, 0, 0, 3, 0);
    do_arm();
    mark();
    frame(8, 2, 0, -1);
    chk("t4c_nwr", nw(), 0);
    chk("t4c_ready", rdy_n - br, 1);
    chk("t4c_short", 32'(short_f), 0);

    // single-shot with an arm during capture: two frames, then idle
    cfgset(1, 0, 0, 0, 0, 2, 2, 'h400);
    do_arm();
    mark();
    frame(8, 4, 0, 1);
    chk("t5_f1_nwr", nw(), 4);
    chk("t5_f1_ready", rdy_n - br, 1);
    chk("t5_f1_busy", 32'(busy), 1);
    mark();
    frame(8, 4, 0, -1);
    chk("t5_f2_nwr", nw(), 4);
    if (nw() > 0) chk("t5_f2_base", wa[bw], 'h400);
    chk("t5_f2_ready", rdy_n - br, 1);
    chk("t5_f2_busy", 32'(busy), 0);
    mark();
    frame(8, 4, 0, -1);
    chk("t5_f3_nwr", nw(), 0);
    chk("t5_f3_ready", rdy_n - br, 0);

    // continuous mode: three frames back to back
    cfgset(1, 0, 1, 0, 0, 1, 1, 'h500);
    do_arm();
    mark();
    for (int f = 0; f < 3; f++) frame(4, 2, 0, -1);
    chk("t5b_nwr", nw(), 3);
    chk("t5b_ready", rdy_n - br, 3);
    chk("t5b_busy", 32'(busy), 1);
    cfg_cont = 1'b0;

    // reset asserted mid-line while writes are in flight
    cfgset(1, 0, 0, 0, 0, 16, 2, 100);
    mark();
    vsync = 1'b1;
    repeat (4) @(negedge clk);
    vsync = 1'b0;
    repeat (3) @(negedge clk);
    for (int c = 0; c < 10; c++) begin
      href = 1'b1;
      data = 8'(c);
      @(negedge clk);
    end
    chk("t6_pre_cenb", 32'(cenb), 0);
    chk("t6_pre_busy", 32'(busy), 1);
    #2 rstn = 1'b0;
    #1;
    chk("t6_cenb", 32'(cenb), 1);
    chk("t6_ab", 32'(ab), 0);
    chk("t6_db", 32'(db), 0);
    chk("t6_busy", 32'(busy), 0);
    @(negedge clk);
    npre = nw();
    for (int c = 10; c < 16; c++) begin
      data = 8'(c);
      if (c == 12) rstn = 1'b1;
      @(negedge clk);
    end
    href = 1'b0;
    repeat (3) @(negedge clk);
    for (int c = 0; c < 16; c++) begin
      href = 1'b1;
      data = 8'(c);
      @(negedge clk);
    end
    href = 1'b0;
    repeat (3) @(negedge clk);
    vsync = 1'b1;
    repeat (8) @(negedge clk);
    chk("t6_ignored_nwr", nw() - npre, 0);
    chk("t6_ignored_ready", rdy_n - br, 0);
    chk("t6_post_busy", 32'(busy), 0);

    cfgset(1, 0, 0, 0, 0, 4, 1, 100);
    do_arm();
    mark();
    frame(4, 1, 0, -1);
    chk("t6_rearm_nwr", nw(), 4);
    for (int i = 0; i < 4 && i < nw(); i++) begin
      chk("t6_rearm_addr", wa[bw+i], 100 + i);
      chk("t6_rearm_data", wd[bw+i], i);
    end
    chk("t6_rearm_ready", rdy_n - br, 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
